// File: rtl/timer_pkg.sv
// Shared types and default sizing for the START/RDY delay timer.
package timer_pkg;

   localparam int unsigned DEF_WIDTH    = 8;
   localparam int unsigned DEF_PRESCALE = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RUN  = 3'b010,
      ST_DONE = 3'b100
   } state_e;

endpackage

// File: rtl/tick_gen.sv
// Modulo-PRESCALE prescaler: tick_c pulses on the last cycle of each period.
module tick_gen
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick_c = en && (cnt == LAST);

   // Clear wins over counting so a reload always starts a full period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick_c ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/start_rdy_timer.sv
// Responder end of the START/RDY handshake: loads a delay on START, pulses RDY when it expires.
module start_rdy_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             START,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic             RDY,
   output logic             BUSY,
   output logic [WIDTH-1:0] COUNT
);

   state_e           state;
   state_e           state_nxt;
   logic             tick_c;
   logic             load_c;
   logic             term_c;
   logic             run_c;
   logic [WIDTH-1:0] load_val_c;

   always_comb begin
      run_c      = (state == ST_RUN);
      load_c     = START && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE));
      term_c     = run_c && tick_c && (COUNT == WIDTH'(1));
      load_val_c = (LOAD_VAL == '0) ? WIDTH'(1) : LOAD_VAL;
   end

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .clear  (load_c),
      .en     (run_c),
      .tick_c (tick_c)
   );

   // Next-state; a reload always beats the terminal tick
   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: state_nxt = START ? ST_RUN : ST_IDLE;
         ST_RUN: begin
            if (START)       state_nxt = ST_RUN;
            else if (term_c) state_nxt = ST_DONE;
            else             state_nxt = ST_RUN;
         end
         ST_DONE: state_nxt = START ? ST_RUN : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register with outputs registered from the next state, so they always match the state decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         BUSY  <= 1'b0;
         RDY   <= 1'b0;
      end else begin
         state <= state_nxt;
         BUSY  <= (state_nxt == ST_RUN);
         RDY   <= (state_nxt == ST_DONE);
      end
   end

   // Loadable down-counter, parked at zero outside RUN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         COUNT <= '0;
      end else if (load_c) begin
         COUNT <= load_val_c;
      end else if (run_c) begin
         if (tick_c && (COUNT != '0)) COUNT <= COUNT - WIDTH'(1);
      end else begin
         COUNT <= '0;
      end
   end

endmodule

// File: tb/tb_start_rdy_timer.sv
// Directed self-checking bench for start_rdy_timer (WIDTH=8, PRESCALE=4).
module tb_start_rdy_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_t;
   logic       ctl_start;
   logic       START;
   logic [7:0] LOAD_VAL;
   logic       RDY;
   logic       BUSY;
   logic [7:0] COUNT;

   int pass_cnt = 0;
   int total    = 0;

   // closed-loop controller state
   logic       ctl_en;
   logic       x;
   int         cst;
   int         n_start;
   int         n_rdy;
   logic       both = 1'b0;

   assign START = start_t | ctl_start;

   always #5 clk = ~clk;

   start_rdy_timer #(.WIDTH(8), .PRESCALE(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .START    (START),
      .LOAD_VAL (LOAD_VAL),
      .RDY      (RDY),
      .BUSY     (BUSY),
      .COUNT    (COUNT)
   );

   always @(negedge clk) if (RDY && BUSY) both <= 1'b1;

   // Six-state X/RDY controller: X rise -> START -> wait RDY -> X fall -> START -> wait RDY
   always @(posedge clk) begin
      if (!ctl_en) begin
         cst <= 0; ctl_start <= 1'b0; n_start <= 0; n_rdy <= 0;
      end else begin
         if (ctl_start) n_start <= n_start + 1;
         if (RDY)       n_rdy   <= n_rdy + 1;
         case (cst)
            0: if (x) cst <= 1;
            1: begin ctl_start <= 1'b1; cst <= 2; end
            2: begin ctl_start <= 1'b0; if (RDY) cst <= 3; end
            3: if (!x) cst <= 4;
            4: begin ctl_start <= 1'b1; cst <= 5; end
            5: begin ctl_start <= 1'b0; if (RDY) cst <= 0; end
            default: cst <= 0;
         endcase
      end
   end

   // Present START with value v so that it is sampled on the next rising edge; return 1ns after it
   task automatic start_at(input logic [7:0] v);
      @(negedge clk);
      start_t  = 1'b1;
      LOAD_VAL = v;
      @(posedge clk);
      #1;
      start_t  = 1'b0;
   endtask

   task automatic test_reset;
      logic seen;
      #12;
      total++; if (RDY !== 1'b0 || BUSY !== 1'b0) $display("FAIL reset_init rdy=%b busy=%b want 0 0", RDY, BUSY); else pass_cnt++;
      total++; if (COUNT !== 8'd0) $display("FAIL reset_init_count got %0d want 0", COUNT); else pass_cnt++;
      @(negedge clk); reset = 1'b0;
      start_at(8'd5);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++; if (BUSY !== 1'b0 || RDY !== 1'b0) $display("FAIL reset_async rdy=%b busy=%b want 0 0", RDY, BUSY); else pass_cnt++;
      total++; if (COUNT !== 8'd0) $display("FAIL reset_async_count got %0d want 0", COUNT); else pass_cnt++;
      @(negedge clk); reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (RDY || BUSY) seen = 1'b1; end
      total++; if (seen !== 1'b0) $display("FAIL reset_no_rdy activity=%b want 0", seen); else pass_cnt++;
   endtask

   task automatic test_basic;
      logic bad = 1'b0;
      start_at(8'd3);
      total++; if (BUSY !== 1'b1 || RDY !== 1'b0 || COUNT !== 8'd3) $display("FAIL basic_start busy=%b rdy=%b count=%0d want 1 0 3", BUSY, RDY, COUNT); else pass_cnt++;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         if (BUSY !== 1'b1 || RDY !== 1'b0) bad = 1'b1;
      end
      total++; if (bad !== 1'b0) $display("FAIL basic_busy_window bad=%b want 0", bad); else pass_cnt++;
      total++; if (COUNT !== 8'd1) $display("FAIL basic_count_k11 got %0d want 1", COUNT); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1 || BUSY !== 1'b0 || COUNT !== 8'd0) $display("FAIL basic_rdy rdy=%b busy=%b count=%0d want 1 0 0", RDY, BUSY, COUNT); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b0 || BUSY !== 1'b0) $display("FAIL basic_after rdy=%b busy=%b want 0 0", RDY, BUSY); else pass_cnt++;
   endtask

   task automatic test_zero_load;
      start_at(8'd0);
      total++; if (COUNT !== 8'd1 || BUSY !== 1'b1) $display("FAIL zero_load count=%0d busy=%b want 1 1", COUNT, BUSY); else pass_cnt++;
      repeat (3) @(posedge clk); #1;
      total++; if (BUSY !== 1'b1 || RDY !== 1'b0) $display("FAIL zero_k3 busy=%b rdy=%b want 1 0", BUSY, RDY); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1 || BUSY !== 1'b0) $display("FAIL zero_rdy rdy=%b busy=%b want 1 0", RDY, BUSY); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b0) $display("FAIL zero_rdy_width rdy=%b want 0", RDY); else pass_cnt++;
   endtask

   task automatic test_retrigger;
      logic bad = 1'b0;
      start_at(8'd5);
      repeat (5) @(posedge clk);
      start_at(8'd2);
      total++; if (COUNT !== 8'd2 || BUSY !== 1'b1 || RDY !== 1'b0) $display("FAIL retrig_reload count=%0d busy=%b rdy=%b want 2 1 0", COUNT, BUSY, RDY); else pass_cnt++;
      repeat (7) begin @(posedge clk); #1; if (RDY !== 1'b0) bad = 1'b1; end
      total++; if (bad !== 1'b0) $display("FAIL retrig_early_rdy bad=%b want 0", bad); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1) $display("FAIL retrig_rdy_k14 rdy=%b want 1", RDY); else pass_cnt++;
      bad = 1'b0;
      repeat (7) begin @(posedge clk); #1; if (RDY !== 1'b0 || BUSY !== 1'b0) bad = 1'b1; end
      total++; if (bad !== 1'b0) $display("FAIL retrig_no_rdy_k20 bad=%b want 0", bad); else pass_cnt++;
   endtask

   task automatic test_simultaneous;
      logic bad = 1'b0;
      start_at(8'd2);
      repeat (7) @(posedge clk);
      start_at(8'd1);
      total++; if (RDY !== 1'b0 || BUSY !== 1'b1 || COUNT !== 8'd1) $display("FAIL simul_reload rdy=%b busy=%b count=%0d want 0 1 1", RDY, BUSY, COUNT); else pass_cnt++;
      repeat (3) begin @(posedge clk); #1; if (RDY !== 1'b0) bad = 1'b1; end
      total++; if (bad !== 1'b0) $display("FAIL simul_early_rdy bad=%b want 0", bad); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1 || BUSY !== 1'b0) $display("FAIL simul_rdy rdy=%b busy=%b want 1 0", RDY, BUSY); else pass_cnt++;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_back_to_back;
      start_at(8'd2);
      repeat (7) @(posedge clk);
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1 || BUSY !== 1'b0) $display("FAIL b2b_first_rdy rdy=%b busy=%b want 1 0", RDY, BUSY); else pass_cnt++;
      start_at(8'd3);
      total++; if (BUSY !== 1'b1 || RDY !== 1'b0 || COUNT !== 8'd3) $display("FAIL b2b_reenter busy=%b rdy=%b count=%0d want 1 0 3", BUSY, RDY, COUNT); else pass_cnt++;
      repeat (11) @(posedge clk); #1;
      total++; if (BUSY !== 1'b1 || RDY !== 1'b0) $display("FAIL b2b_pre busy=%b rdy=%b want 1 0", BUSY, RDY); else pass_cnt++;
      @(posedge clk); #1;
      total++; if (RDY !== 1'b1 || BUSY !== 1'b0) $display("FAIL b2b_second_rdy rdy=%b busy=%b want 1 0", RDY, BUSY); else pass_cnt++;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_closed_loop;
      logic timeout = 1'b0;
      int   n;
      LOAD_VAL = 8'd1;
      @(negedge clk); ctl_en = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk); x = 1'b1;
         n = 0;
         while (cst != 3 && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) timeout = 1'b1;
         x = 1'b0;
         n = 0;
         while (cst != 0 && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) timeout = 1'b1;
      end
      repeat (3) @(negedge clk);
      total++; if (timeout !== 1'b0) $display("FAIL loop_timeout timeout=%b want 0", timeout); else pass_cnt++;
      total++; if (n_start != 6 || n_rdy != 6) $display("FAIL loop_counts starts=%0d rdys=%0d want 6 6", n_start, n_rdy); else pass_cnt++;
      total++; if (cst != 0 || BUSY !== 1'b0) $display("FAIL loop_final state=%0d busy=%b want 0 0", cst, BUSY); else pass_cnt++;
      ctl_en = 1'b0;
      total++; if (both !== 1'b0) $display("FAIL rdy_busy_overlap seen=%b want 0", both); else pass_cnt++;
   endtask

   initial begin
      reset    = 1'b1;
      start_t  = 1'b0;
      ctl_en   = 1'b0;
      x        = 1'b0;
      LOAD_VAL = 8'd0;
      test_reset();
      test_basic();
      test_zero_load();
      test_retrigger();
      test_simultaneous();
      test_back_to_back();
      test_closed_loop();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
